// File: rtl/shift_rows_pipe.sv
// Registered AES ShiftRows / InvShiftRows stage for 4, 6 or 8 columns,
// with a small output FIFO so downstream back-pressure never reaches the transform.
module shift_rows_pipe #(
  parameter int NB    = 4,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [32*NB-1:0]             in_data,
  input  logic                         in_inv,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [32*NB-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int W  = 32 * NB;
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("shift_rows_pipe: DEPTH must be a power of 2 and at least 2");
  end

  // Rijndael row offsets: the 8-column state shifts rows 2 and 3 one further.
  function automatic int row_shift(input int r);
    if (r < 2)        return r;
    else if (NB == 8) return r + 1;
    else              return r;
  endfunction

  logic [W-1:0] xf;

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int SH   = row_shift(r);
      localparam int FSRC = (c + SH) % NB;
      localparam int ISRC = (c + NB - SH) % NB;
      assign xf[W-1-8*(r+4*c) -: 8] = in_inv ? in_data[W-1-8*(r+4*ISRC) -: 8]
                                             : in_data[W-1-8*(r+4*FSRC) -: 8];
    end
  end

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push, pop;

  assign in_ready  = (level_q != LW'(DEPTH));
  assign out_valid = (level_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign level     = level_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = xf;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Scoreboard bench for shift_rows_pipe: NB=4 (DEPTH=4), NB=6 and NB=8 (DEPTH=2) instances.
module tb_shift_rows_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         in_valid4, in_ready4, in_inv4, out_valid4, out_ready4;
  logic [127:0] in_data4, out_data4;
  logic [2:0]   level4;
  logic         in_valid6, in_ready6, in_inv6, out_valid6, out_ready6;
  logic [191:0] in_data6, out_data6;
  logic [1:0]   level6;
  logic         in_valid8, in_ready8, in_inv8, out_valid8, out_ready8;
  logic [255:0] in_data8, out_data8;
  logic [1:0]   level8;

  shift_rows_pipe #(.NB(4), .DEPTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_data(in_data4), .in_inv(in_inv4), .out_valid(out_valid4),
    .out_ready(out_ready4), .out_data(out_data4), .level(level4));
  shift_rows_pipe #(.NB(6), .DEPTH(2)) u6 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid6), .in_ready(in_ready6),
    .in_data(in_data6), .in_inv(in_inv6), .out_valid(out_valid6),
    .out_ready(out_ready6), .out_data(out_data6), .level(level6));
  shift_rows_pipe #(.NB(8), .DEPTH(2)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_data(in_data8), .in_inv(in_inv8), .out_valid(out_valid8),
    .out_ready(out_ready8), .out_data(out_data8), .level(level8));

  int n_tests = 0;
  int n_fail  = 0;
  logic [255:0] q4[$], q6[$], q8[$];

  localparam logic [127:0] FIPS_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

  // Reference model on a right-aligned state of nb columns.
  function automatic logic [255:0] ref_sr(input int nb, input logic [255:0] din, input logic inv);
    logic [7:0]   st [4][8];
    logic [255:0] dout;
    int s, src;
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = din[32*nb-1-8*(r+4*c) -: 8];
    dout = '0;
    for (int r = 0; r < 4; r++) begin
      s = (r < 2) ? r : ((nb == 8) ? r + 1 : r);
      for (int c = 0; c < nb; c++) begin
        src = inv ? (c - s + nb) % nb : (c + s) % nb;
        dout[32*nb-1-8*(r+4*c) -: 8] = st[r][src];
      end
    end
    return dout;
  endfunction

  // Drivers: called at a falling edge, advance one cycle, report any pop.
  task automatic step4(input logic v, input logic [127:0] d, input logic inv, input logic rdy,
                       output logic popped, output logic [255:0] got);
    in_valid4 = v; in_data4 = d; in_inv4 = inv; out_ready4 = rdy;
    popped = out_valid4 && rdy;
    got    = {128'b0, out_data4};
    if (v && in_ready4) q4.push_back(ref_sr(4, {128'b0, d}, inv));
    @(posedge clk); @(negedge clk);
  endtask

  task automatic step6(input logic v, input logic [191:0] d, input logic inv, input logic rdy,
                       output logic popped, output logic [255:0] got);
    in_valid6 = v; in_data6 = d; in_inv6 = inv; out_ready6 = rdy;
    popped = out_valid6 && rdy;
    got    = {64'b0, out_data6};
    if (v && in_ready6) q6.push_back(ref_sr(6, {64'b0, d}, inv));
    @(posedge clk); @(negedge clk);
  endtask

  task automatic step8(input logic v, input logic [255:0] d, input logic inv, input logic rdy,
                       output logic popped, output logic [255:0] got);
    in_valid8 = v; in_data8 = d; in_inv8 = inv; out_ready8 = rdy;
    popped = out_valid8 && rdy;
    got    = out_data8;
    if (v && in_ready8) q8.push_back(ref_sr(8, d, inv));
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset;
    n_tests++; if (out_valid4 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid4 got %b want 0", out_valid4); end
    n_tests++; if (level4 !== 3'd0) begin n_fail++; $display("FAIL reset_level4 got %0d want 0", level4); end
    n_tests++; if (in_ready4 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready4 got %b want 1", in_ready4); end
    n_tests++; if (out_data4 !== 128'h0) begin n_fail++; $display("FAIL reset_out_data4 got %h want 0", out_data4); end
    n_tests++; if (out_valid6 !== 1'b0 || level6 !== 2'd0) begin n_fail++; $display("FAIL reset_nb6 got valid=%b level=%0d want 0/0", out_valid6, level6); end
    n_tests++; if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin n_fail++; $display("FAIL reset_nb8 got valid=%b ready=%b want 0/1", out_valid8, in_ready8); end
  endtask

  task automatic test_fips4(input logic [127:0] din, input logic inv, input logic [127:0] want);
    logic p; logic [255:0] g, e;
    step4(1'b1, din, inv, 1'b1, p, g);
    n_tests++;
    if (out_valid4 !== 1'b1 || out_data4 !== want) begin
      n_fail++; $display("FAIL fips4_inv%0d got valid=%b data=%h want 1/%h", inv, out_valid4, out_data4, want);
    end
    step4(1'b0, '0, 1'b0, 1'b1, p, g);
    n_tests++;
    if (!p || q4.size() == 0) begin
      n_fail++; $display("FAIL fips4_sb_inv%0d got popped=%b queued=%0d want 1/1", inv, p, q4.size());
    end else begin
      e = q4.pop_front();
      if (g !== e) begin n_fail++; $display("FAIL fips4_sb_inv%0d got %h want %h", inv, g, e); end
    end
  endtask

  task automatic test_stream4;
    logic p; logic [255:0] g, e;
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if (in_ready4 !== 1'b1) begin n_fail++; $display("FAIL stream4_ready[%0d] got %b want 1", i, in_ready4); end
      step4(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'(i % 2), 1'b1, p, g);
      if (p) begin
        n_tests++;
        if (q4.size() == 0) begin n_fail++; $display("FAIL stream4_extra got %h want none", g); end
        else begin e = q4.pop_front(); if (g !== e) begin n_fail++; $display("FAIL stream4_data got %h want %h", g, e); end end
      end
    end
    for (int k = 0; k < 8 && q4.size() != 0; k++) begin
      step4(1'b0, '0, 1'b0, 1'b1, p, g);
      if (p) begin
        n_tests++; e = q4.pop_front();
        if (g !== e) begin n_fail++; $display("FAIL stream4_drain got %h want %h", g, e); end
      end
    end
    n_tests++;
    if (q4.size() != 0 || out_valid4 !== 1'b0) begin
      n_fail++; $display("FAIL stream4_empty got queued=%0d valid=%b want 0/0", q4.size(), out_valid4);
    end
  endtask

  task automatic test_backpressure4;
    logic p; logic [255:0] g, e;
    int acc = 0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        n_tests++;
        if (out_valid4 !== 1'b1 || {128'b0, out_data4} !== q4[0]) begin
          n_fail++; $display("FAIL bp_hold[%0d] got valid=%b data=%h want 1/%h", i, out_valid4, out_data4, q4[0]);
        end
      end
      if (in_ready4) acc++;
      step4(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'(i % 2), 1'b0, p, g);
    end
    n_tests++; if (acc != 4) begin n_fail++; $display("FAIL bp_accepted got %0d want 4", acc); end
    n_tests++; if (level4 !== 3'd4 || in_ready4 !== 1'b0) begin n_fail++; $display("FAIL bp_full got level=%0d ready=%b want 4/0", level4, in_ready4); end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (out_valid4 !== 1'b1) begin n_fail++; $display("FAIL bp_release_valid[%0d] got %b want 1", i, out_valid4); end
      step4(1'b0, '0, 1'b0, 1'b1, p, g);
      n_tests++;
      if (!p || q4.size() == 0) begin n_fail++; $display("FAIL bp_release_pop[%0d] got popped=%b want 1", i, p); end
      else begin e = q4.pop_front(); if (g !== e) begin n_fail++; $display("FAIL bp_release_data[%0d] got %h want %h", i, g, e); end end
      if (i == 0) begin
        n_tests++; if (in_ready4 !== 1'b1) begin n_fail++; $display("FAIL bp_ready_return got %b want 1", in_ready4); end
      end
    end
    n_tests++; if (out_valid4 !== 1'b0 || level4 !== 3'd0) begin n_fail++; $display("FAIL bp_empty got valid=%b level=%0d want 0/0", out_valid4, level4); end
    // Simultaneous push and pop at level 2.
    step4(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, p, g);
    step4(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, p, g);
    n_tests++; if (level4 !== 3'd2) begin n_fail++; $display("FAIL pp_fill got level=%0d want 2", level4); end
    step4(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1, p, g);
    n_tests++; if (level4 !== 3'd2) begin n_fail++; $display("FAIL pp_level got level=%0d want 2", level4); end
    n_tests++;
    if (!p || q4.size() == 0) begin n_fail++; $display("FAIL pp_pop got popped=%b want 1", p); end
    else begin e = q4.pop_front(); if (g !== e) begin n_fail++; $display("FAIL pp_data got %h want %h", g, e); end end
    for (int k = 0; k < 6 && q4.size() != 0; k++) begin
      step4(1'b0, '0, 1'b0, 1'b1, p, g);
      if (p) begin
        n_tests++; e = q4.pop_front();
        if (g !== e) begin n_fail++; $display("FAIL pp_drain got %h want %h", g, e); end
      end
    end
    n_tests++; if (q4.size() != 0) begin n_fail++; $display("FAIL pp_drain_empty got queued=%0d want 0", q4.size()); end
  endtask

  task automatic test_reset_mid4;
    logic p; logic [255:0] g, e;
    for (int i = 0; i < 3; i++) step4(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, p, g);
    n_tests++; if (level4 !== 3'd3) begin n_fail++; $display("FAIL rmid_fill got level=%0d want 3", level4); end
    #2 rst_n = 1'b0; in_valid4 = 1'b0;
    #1;
    n_tests++;
    if (out_valid4 !== 1'b0 || level4 !== 3'd0 || in_ready4 !== 1'b1 || out_data4 !== 128'h0) begin
      n_fail++; $display("FAIL rmid_async got valid=%b level=%0d ready=%b data=%h want 0/0/1/0", out_valid4, level4, in_ready4, out_data4);
    end
    q4.delete();
    @(negedge clk); rst_n = 1'b1;
    step4(1'b1, FIPS_IN, 1'b0, 1'b1, p, g);
    n_tests++;
    if (out_valid4 !== 1'b1 || level4 !== 3'd1 || out_data4 !== FIPS_OUT) begin
      n_fail++; $display("FAIL rmid_after got valid=%b level=%0d data=%h want 1/1/%h", out_valid4, level4, out_data4, FIPS_OUT);
    end
    step4(1'b0, '0, 1'b0, 1'b1, p, g);
    n_tests++;
    if (!p || q4.size() == 0) begin n_fail++; $display("FAIL rmid_pop got popped=%b want 1", p); end
    else begin e = q4.pop_front(); if (g !== e) begin n_fail++; $display("FAIL rmid_data got %h want %h", g, e); end end
    n_tests++; if (out_valid4 !== 1'b0) begin n_fail++; $display("FAIL rmid_stale got valid=%b want 0", out_valid4); end
  endtask

  task automatic test_nb8;
    logic p; logic [255:0] g, e, din, fwd;
    for (int k = 0; k < 32; k++) din[255-8*k -: 8] = 8'(k);
    fwd = ref_sr(8, din, 1'b0);
    step8(1'b1, din, 1'b0, 1'b1, p, g);
    n_tests++;
    if (out_valid8 !== 1'b1 || out_data8[255:224] !== 32'h00050e13) begin
      n_fail++; $display("FAIL nb8_col0 got valid=%b col=%h want 1/00050e13", out_valid8, out_data8[255:224]);
    end
    step8(1'b1, fwd, 1'b1, 1'b1, p, g);
    n_tests++;
    if (!p || q8.size() == 0) begin n_fail++; $display("FAIL nb8_fwd_pop got popped=%b want 1", p); end
    else begin e = q8.pop_front(); if (g !== e) begin n_fail++; $display("FAIL nb8_fwd got %h want %h", g, e); end end
    step8(1'b0, '0, 1'b0, 1'b1, p, g);
    n_tests++;
    if (!p || q8.size() == 0) begin n_fail++; $display("FAIL nb8_inv_pop got popped=%b want 1", p); end
    else begin e = q8.pop_front(); if (g !== e || g !== din) begin n_fail++; $display("FAIL nb8_roundtrip got %h want %h", g, din); end end
  endtask

  task automatic test_nb6;
    logic p; logic [255:0] g, e, fwd;
    logic [191:0] din;
    for (int k = 0; k < 24; k++) din[191-8*k -: 8] = 8'(k);
    fwd = ref_sr(6, {64'b0, din}, 1'b0);
    step6(1'b1, din, 1'b0, 1'b1, p, g);
    n_tests++;
    if (out_valid6 !== 1'b1 || out_data6[191:160] !== 32'h00050a0f) begin
      n_fail++; $display("FAIL nb6_col0 got valid=%b col=%h want 1/00050a0f", out_valid6, out_data6[191:160]);
    end
    step6(1'b1, fwd[191:0], 1'b1, 1'b1, p, g);
    n_tests++;
    if (!p || q6.size() == 0) begin n_fail++; $display("FAIL nb6_fwd_pop got popped=%b want 1", p); end
    else begin e = q6.pop_front(); if (g !== e) begin n_fail++; $display("FAIL nb6_fwd got %h want %h", g, e); end end
    step6(1'b0, '0, 1'b0, 1'b1, p, g);
    n_tests++;
    if (!p || q6.size() == 0) begin n_fail++; $display("FAIL nb6_inv_pop got popped=%b want 1", p); end
    else begin e = q6.pop_front(); if (g !== e || g[191:0] !== din) begin n_fail++; $display("FAIL nb6_roundtrip got %h want %h", g[191:0], din); end end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_valid4 = 1'b0; in_data4 = '0; in_inv4 = 1'b0; out_ready4 = 1'b0;
    in_valid6 = 1'b0; in_data6 = '0; in_inv6 = 1'b0; out_ready6 = 1'b0;
    in_valid8 = 1'b0; in_data8 = '0; in_inv8 = 1'b0; out_ready8 = 1'b0;
    @(negedge clk); @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_fips4(FIPS_IN, 1'b0, FIPS_OUT);
    test_fips4(FIPS_OUT, 1'b1, FIPS_IN);
    test_stream4();
    test_nb8();
    test_nb6();
    test_backpressure4();
    test_reset_mid4();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
